// File: rtl/i2c_resp_pkg.sv
// ----------------------------------------------------------------------------
// i2c_resp_pkg
// Shared types and constants for the I2C target responder.
//   i2c_resp_state_t : byte-level FSM states of the responder
//   I2C_RW_READ      : value of the R/W bit that requests a read
//   BIT_CNT_W        : width of the per-byte bit counter (counts 0..9)
// ----------------------------------------------------------------------------
package i2c_resp_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WR,
      WR_ACK,
      RD,
      RD_ACK,
      IGNORE
   } i2c_resp_state_t;

   localparam logic I2C_RW_READ = 1'b1;

   // 8 data bits plus the ACK phase; value 9 marks "ACK bit clocked".
   localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Brings the raw SCL/SDA bus levels into the clk domain and produces one-cycle
// event pulses. Every pulse is registered, so an event appears 3 clk cycles
// after the bus edge (two synchronizer flops plus the pulse register).
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   scl_raw    : raw SCL level
//   sda_raw    : raw SDA level
//   sda_s      : synchronized SDA sample aligned with the event pulses
//   scl_rise   : SCL rising edge pulse
//   scl_fall   : SCL falling edge pulse
//   start_det  : SDA fall while SCL high
//   stop_det   : SDA rise while SCL high
// ----------------------------------------------------------------------------
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_raw,
   input  logic sda_raw,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_prev;
   logic       sda_prev;

   // The synchronizers reset to the idle bus level (high) so leaving reset
   // on an idle bus never produces a false START or edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync  <= 2'b11;
         sda_sync  <= 2'b11;
         scl_prev  <= 1'b1;
         sda_prev  <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         scl_sync  <= {scl_sync[0], scl_raw};
         sda_sync  <= {sda_sync[0], sda_raw};
         scl_prev  <= scl_sync[1];
         sda_prev  <= sda_sync[1];
         scl_rise  <= scl_sync[1] & ~scl_prev;
         scl_fall  <= ~scl_sync[1] & scl_prev;
         start_det <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
         stop_det  <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
      end
   end

   // sda_prev holds the sample that produced the current pulse.
   assign sda_s = sda_prev;

endmodule

// File: rtl/i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// i2c_slave_responder
// I2C target answering SLAVE_ADDR, backed by a MEM_DEPTH-byte register file
// addressed through a persistent register pointer. Write transfers load the
// pointer with the first byte and store the following bytes; read transfers
// return bytes from the pointer onward. The pointer auto-increments and wraps.
// Optional build macro I2C_RESP_STRETCH_EN: hold SCL low for STRETCH_CYCLES
// clocks after each ACK bit of PTR/WR/RD bytes; otherwise scl_oe_o is 0.
// Ports:
//   clk_i, rst_i : system clock (>= 8x SCL), synchronous active-high reset
//   scl_i, sda_i : raw bus levels
//   sda_oe_o     : 1 pulls SDA low
//   scl_oe_o     : 1 pulls SCL low (clock stretch)
//   busy_o       : address-matched transfer in progress (until STOP)
//   wr_strobe_o  : one-cycle pulse per committed byte; wr_ptr_o/wr_data_o
//                  carry the address and byte and are only meaningful in the
//                  strobe cycle (no back-pressure: consumers must take it)
// ----------------------------------------------------------------------------
module i2c_slave_responder
   import i2c_resp_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR     = 7'h22,
   parameter int         MEM_DEPTH      = 16,
   parameter int         STRETCH_CYCLES = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         scl_i,
   input  logic                         sda_i,
   output logic                         sda_oe_o,
   output logic                         scl_oe_o,
   output logic                         busy_o,
   output logic                         wr_strobe_o,
   output logic [$clog2(MEM_DEPTH)-1:0] wr_ptr_o,
   output logic [7:0]                   wr_data_o
);

   localparam int PTR_W = $clog2(MEM_DEPTH);

   i2c_resp_state_t       state, state_next;
   logic [BIT_CNT_W-1:0]  bit_cnt, cnt_next;
   logic [7:0]            shreg;
   logic [7:0]            rx_byte;
   logic [PTR_W-1:0]      ptr;
   logic [7:0]            mem [MEM_DEPTH];
   logic                  fall_d;
   logic                  sda_drive;
   logic                  addr_hit;
   logic                  stretching;

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic scl_rise_g, scl_fall_g;

   logic shift_en, ptr_load, ptr_inc, mem_wr, rd_load, busy_set;

   i2c_line_sync u_sync (
      .clk       (clk_i),
      .rst       (rst_i),
      .scl_raw   (scl_i),
      .sda_raw   (sda_i),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // Edges seen while this block holds SCL low are not controller clocks.
   assign scl_rise_g = scl_rise & ~stretching;
   assign scl_fall_g = scl_fall & ~stretching;

   assign rx_byte  = {shreg[6:0], sda_s};
   assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Byte FSM. bit_cnt counts SCL rises within a byte; in ACK states it is 8
   // until the ACK-bit rise (sets 9), and the following fall closes the byte.
   always_comb begin
      state_next = state;
      cnt_next   = bit_cnt;
      shift_en   = 1'b0;
      ptr_load   = 1'b0;
      ptr_inc    = 1'b0;
      mem_wr     = 1'b0;
      rd_load    = 1'b0;
      busy_set   = 1'b0;
      if (stop_det) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else if (start_det) begin
         state_next = ADDR;
         cnt_next   = '0;
      end else if (scl_rise_g) begin
         case (state)
            ADDR, PTR, WR: begin
               shift_en = 1'b1;
               cnt_next = bit_cnt + 1'b1;
               if (bit_cnt == BIT_CNT_W'(7)) begin
                  if (state == ADDR) begin
                     if (addr_hit) begin
                        state_next = ADDR_ACK;
                        busy_set   = 1'b1;
                     end else begin
                        state_next = IGNORE;
                     end
                  end else if (state == PTR) begin
                     ptr_load   = 1'b1;
                     state_next = PTR_ACK;
                  end else begin
                     mem_wr     = 1'b1;
                     state_next = WR_ACK;
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WR_ACK: begin
               if (bit_cnt == BIT_CNT_W'(8)) cnt_next = BIT_CNT_W'(9);
            end
            RD: begin
               cnt_next = bit_cnt + 1'b1;
               if (bit_cnt == BIT_CNT_W'(7)) state_next = RD_ACK;
            end
            RD_ACK: begin
               if (bit_cnt == BIT_CNT_W'(8)) begin
                  if (!sda_s) begin
                     ptr_inc  = 1'b1;
                     cnt_next = BIT_CNT_W'(9);
                  end else begin
                     state_next = IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end else if (scl_fall_g && bit_cnt == BIT_CNT_W'(9)) begin
         case (state)
            ADDR_ACK: begin
               cnt_next = '0;
               if (shreg[0] == I2C_RW_READ) begin
                  state_next = RD;
                  rd_load    = 1'b1;
               end else begin
                  state_next = PTR;
               end
            end
            PTR_ACK: begin
               cnt_next   = '0;
               state_next = WR;
            end
            WR_ACK: begin
               cnt_next   = '0;
               state_next = WR;
               ptr_inc    = 1'b1;
            end
            RD_ACK: begin
               cnt_next   = '0;
               state_next = RD;
               rd_load    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // SDA level to present for the bit that follows the latest SCL fall.
   always_comb begin
      sda_drive = 1'b0;
      case (state)
         ADDR_ACK, PTR_ACK, WR_ACK: sda_drive = (bit_cnt == BIT_CNT_W'(8));
         RD: if (bit_cnt < BIT_CNT_W'(8)) sda_drive = ~shreg[3'd7 - bit_cnt[2:0]];
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt     <= '0;
         shreg       <= '0;
         ptr         <= '0;
         fall_d      <= 1'b0;
         sda_oe_o    <= 1'b0;
         busy_o      <= 1'b0;
         wr_strobe_o <= 1'b0;
         wr_ptr_o    <= '0;
         wr_data_o   <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         bit_cnt     <= cnt_next;
         fall_d      <= scl_fall_g;
         wr_strobe_o <= mem_wr;
         if (shift_en)     shreg <= rx_byte;
         else if (rd_load) shreg <= mem[ptr];
         if (ptr_load)     ptr <= rx_byte[PTR_W-1:0];
         else if (ptr_inc) ptr <= ptr + 1'b1;
         if (mem_wr) begin
            mem[ptr]  <= rx_byte;
            wr_ptr_o  <= ptr;
            wr_data_o <= rx_byte;
         end
         if (busy_set)      busy_o <= 1'b1;
         else if (stop_det) busy_o <= 1'b0;
         // SDA only moves one cycle after a seen SCL fall (hold time),
         // except that START/STOP release it at once.
         if (start_det || stop_det) sda_oe_o <= 1'b0;
         else if (fall_d)           sda_oe_o <= sda_drive;
      end
   end

`ifdef I2C_RESP_STRETCH_EN
   localparam int SW = $clog2(STRETCH_CYCLES + 1);
   logic [SW-1:0] stretch_cnt;
   logic          ack_fall;

   assign ack_fall = scl_fall_g && (bit_cnt == BIT_CNT_W'(9)) &&
                     (state inside {PTR_ACK, WR_ACK, RD_ACK});
   assign stretching = scl_oe_o;

   always_ff @(posedge clk_i) begin
      if (rst_i || start_det || stop_det) begin
         stretch_cnt <= '0;
         scl_oe_o    <= 1'b0;
      end else if (ack_fall) begin
         stretch_cnt <= SW'(STRETCH_CYCLES);
         scl_oe_o    <= 1'b1;
      end else if (stretch_cnt != '0) begin
         stretch_cnt <= stretch_cnt - SW'(1);
         if (stretch_cnt == SW'(1)) scl_oe_o <= 1'b0;
      end
   end
`else
   assign stretching = 1'b0;
   assign scl_oe_o   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_responder
// Directed bench: a bit-level I2C controller model drives the open-drain bus,
// a monitor records write strobes, and each check is an immediate assertion.
// ----------------------------------------------------------------------------
module tb_i2c_slave_responder;

   localparam int Q = 4;  // quarter SCL period in clk cycles
`ifdef I2C_RESP_STRETCH_EN
   localparam int EXP_RUNS = 3;
`else
   localparam int EXP_RUNS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_i;
   logic       m_scl, m_sda;
   logic       sda_oe_o, scl_oe_o, busy_o, wr_strobe_o;
   logic [3:0] wr_ptr_o;
   logic [7:0] wr_data_o;
   logic       scl_bus, sda_bus;

   int n_assert = 0;
   int n_fail   = 0;

   logic [11:0] exp_q[$];
   logic [11:0] obs_q[$];
   int          run_q[$];
   int          run_len = 0;

   assign scl_bus = m_scl & ~scl_oe_o;
   assign sda_bus = m_sda & ~sda_oe_o;

   i2c_slave_responder dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .scl_i       (scl_bus),
      .sda_i       (sda_bus),
      .sda_oe_o    (sda_oe_o),
      .scl_oe_o    (scl_oe_o),
      .busy_o      (busy_o),
      .wr_strobe_o (wr_strobe_o),
      .wr_ptr_o    (wr_ptr_o),
      .wr_data_o   (wr_data_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (wr_strobe_o === 1'b1) obs_q.push_back({wr_ptr_o, wr_data_o});
      if (scl_oe_o === 1'b1) begin
         run_len++;
      end else if (run_len > 0) begin
         run_q.push_back(run_len);
         run_len = 0;
      end
   end

   // ---------------- check helper ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic scl_high();
      int t = 0;
      m_scl = 1'b1;
      while (scl_bus !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("scl_release_timeout", {31'd0, scl_bus}, 32'd1);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wait_q();
      scl_high();   wait_q();
      m_sda = 1'b0; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wait_q();
      scl_high();   wait_q();
      m_sda = 1'b1; wait_q(); wait_q();
   endtask

   task automatic send_bit(input logic b);
      m_sda = b; wait_q();
      scl_high(); wait_q(); wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic recv_bit(output logic b);
      m_sda = 1'b1; wait_q();
      scl_high(); wait_q();
      b = sda_bus; wait_q();
      m_scl = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic a;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(a);
      ack = ~a;
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic ack);
      logic b;
      d = '0;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d = {d[6:0], b};
      end
      send_bit(~ack);
   endtask

   // Write transaction that only sets the register pointer.
   task automatic set_ptr(input logic [7:0] p);
      logic a;
      i2c_start();
      send_byte(8'h44, a); chk("set_ptr_addr_ack", {31'd0, a}, 32'd1);
      send_byte(p, a);     chk("set_ptr_ptr_ack",  {31'd0, a}, 32'd1);
      i2c_stop();
   endtask

   task automatic check_strobes(input string tag);
      logic [11:0] e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
         chk(tag, {20'd0, o}, {20'd0, e});
      end
      chk({tag, "_extra"}, obs_q.size(), 32'd0);
      obs_q.delete();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic       a;
      logic [7:0] d;

      rst_i = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_sda_oe",    {31'd0, sda_oe_o},    32'd0);
      chk("rst_scl_oe",    {31'd0, scl_oe_o},    32'd0);
      chk("rst_busy",      {31'd0, busy_o},      32'd0);
      chk("rst_wr_strobe", {31'd0, wr_strobe_o}, 32'd0);
      chk("rst_wr_ptr",    {28'd0, wr_ptr_o},    32'd0);
      chk("rst_wr_data",   {24'd0, wr_data_o},   32'd0);

      // T1: write ptr 3, data A5 5A
      i2c_start();
      send_byte(8'h44, a); chk("t1_addr_ack", {31'd0, a}, 32'd1);
      chk("t1_busy_high", {31'd0, busy_o}, 32'd1);
      send_byte(8'h03, a); chk("t1_ptr_ack", {31'd0, a}, 32'd1);
      send_byte(8'hA5, a); chk("t1_d0_ack",  {31'd0, a}, 32'd1);
      send_byte(8'h5A, a); chk("t1_d1_ack",  {31'd0, a}, 32'd1);
      i2c_stop();
      chk("t1_busy_low", {31'd0, busy_o}, 32'd0);
      exp_q.push_back({4'h3, 8'hA5});
      exp_q.push_back({4'h4, 8'h5A});
      check_strobes("t1_strobe");
      chk("t1_stretch_runs", run_q.size(), EXP_RUNS);
      while (run_q.size() > 0) chk("t1_stretch_len", run_q.pop_front(), 32'd8);

      // T2: set ptr 3, read A5 (ACK), 5A (NACK)
      set_ptr(8'h03);
      i2c_start();
      send_byte(8'h45, a); chk("t2_addr_ack", {31'd0, a}, 32'd1);
      recv_byte(d, 1'b1);  chk("t2_rd0", {24'd0, d}, 32'hA5);
      recv_byte(d, 1'b0);  chk("t2_rd1", {24'd0, d}, 32'h5A);
      repeat (8) @(negedge clk);
      chk("t2_sda_released", {31'd0, sda_oe_o}, 32'd0);
      i2c_stop();
      check_strobes("t2_strobe");

      // T3: wrong address 0x23 write, nothing acknowledged or stored
      i2c_start();
      send_byte(8'h46, a); chk("t3_addr_nack", {31'd0, a}, 32'd0);
      chk("t3_busy_low", {31'd0, busy_o}, 32'd0);
      send_byte(8'h03, a); chk("t3_ptr_nack", {31'd0, a}, 32'd0);
      send_byte(8'hFF, a); chk("t3_d_nack",   {31'd0, a}, 32'd0);
      i2c_stop();
      check_strobes("t3_strobe");
      set_ptr(8'h03);
      i2c_start();
      send_byte(8'h45, a);
      recv_byte(d, 1'b0);  chk("t3_mem3_kept", {24'd0, d}, 32'hA5);
      i2c_stop();

      // T4: pointer wrap on write, repeated START, read mem[1]
      i2c_start();
      send_byte(8'h44, a); chk("t4_addr_ack", {31'd0, a}, 32'd1);
      send_byte(8'h0F, a); chk("t4_ptr_ack",  {31'd0, a}, 32'd1);
      send_byte(8'h11, a); chk("t4_d0_ack",   {31'd0, a}, 32'd1);
      send_byte(8'h22, a); chk("t4_d1_ack",   {31'd0, a}, 32'd1);
      i2c_start();
      send_byte(8'h45, a); chk("t4_rs_addr_ack", {31'd0, a}, 32'd1);
      recv_byte(d, 1'b0);  chk("t4_rd_mem1", {24'd0, d}, 32'h00);
      i2c_stop();
      exp_q.push_back({4'hF, 8'h11});
      exp_q.push_back({4'h0, 8'h22});
      check_strobes("t4_strobe");
      set_ptr(8'h0F);
      i2c_start();
      send_byte(8'h45, a);
      recv_byte(d, 1'b1);  chk("t4_rd_mem15", {24'd0, d}, 32'h11);
      recv_byte(d, 1'b0);  chk("t4_rd_mem0_wrap", {24'd0, d}, 32'h22);
      i2c_stop();

      // T5: reset while the responder is driving a 0 data bit
      set_ptr(8'h03);
      i2c_start();
      send_byte(8'h45, a);
      recv_bit(a);         chk("t5_bit7", {31'd0, a}, 32'd1);
      repeat (3) @(negedge clk);
      chk("t5_sda_driven", {31'd0, sda_oe_o}, 32'd1);
      rst_i = 1'b1;
      @(negedge clk);
      chk("t5_sda_rel_after_rst", {31'd0, sda_oe_o}, 32'd0);
      chk("t5_busy_after_rst",    {31'd0, busy_o},   32'd0);
      rst_i = 1'b0;
      m_scl = 1'b1; wait_q();
      m_sda = 1'b1; wait_q();
      set_ptr(8'h03);
      i2c_start();
      send_byte(8'h45, a);
      recv_byte(d, 1'b0);  chk("t5_mem_cleared", {24'd0, d}, 32'h00);
      i2c_stop();
      check_strobes("t5_strobe");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (responder) sitting at the far end of the I2CMB-driven I2C bus.
- Answers one 7-bit address and backs it with a small byte register file using register-pointer addressing.
- Used as an RTL target in place of, or alongside, the behavioural i2c agent, and later as a reusable peripheral.
- Samples SCL/SDA with the system clock and drives open-drain enables only.

Parameters:
- SLAVE_ADDR, 7'h22, 7-bit address this block acknowledges.
- MEM_DEPTH, 16, number of bytes in the register file; power of two, 2..256.
- STRETCH_CYCLES, 8, clk_i cycles of SCL hold-low per stretch (used only with the optional feature).

Ports:
- clk_i  in  1  system clock; SCL must be at most clk_i/8.
- rst_i  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- scl_i  in  1  raw SCL bus level.
- sda_i  in  1  raw SDA bus level.
- sda_oe_o  out  1  1 = pull SDA low; 0 = release.
- scl_oe_o  out  1  1 = pull SCL low (stretch); constant 0 without the feature.
- busy_o  out  1  high from an address-matched START until STOP.
- wr_strobe_o  out  1  one-cycle pulse when a data byte is committed to memory.
- wr_ptr_o  out  $clog2(MEM_DEPTH)  address written; valid with wr_strobe_o.
- wr_data_o  out  8  byte written; valid with wr_strobe_o.

Behaviour:
- Reset values:
  - All outputs 0.
  - Memory cleared to 8'h00.
  - Pointer 0.
  - FSM in IDLE.
- Reset mid-transfer releases both lines on the next cycle.
- Input sampling:
  - scl_i/sda_i pass through a 2-flop synchronizer.
  - Edges are detected against the previous synchronized sample.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Detection latency is 3 clk_i cycles from the bus edge.
- Bit timing:
  - Data and ACK bits are sampled on SCL rise.
  - sda_oe_o changes only 1 cycle after a detected SCL fall, giving SDA hold time.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- START (including a repeated START) in any state → ADDR, bit counter cleared.
- STOP in any state → IDLE, busy_o=0, outputs released.
- ADDR:
  - Shift 8 bits MSB first.
  - Address match → ADDR_ACK, drive SDA low for the 9th clock.
  - Mismatch → IGNORE, no drive.
- After ADDR_ACK, R/W bit selects the next state:
  - R/W=0 → PTR.
  - R/W=1 → RD; load shift register with mem[ptr]; drive the MSB immediately on ACK-release.
- PTR: received byte → ptr = byte mod MEM_DEPTH; ACK; then WR.
- WR:
  - Received byte → mem[ptr] written.
  - wr_strobe_o pulses 1 cycle after the 8th SCL rise.
  - ACK, then ptr = ptr+1, wrapping MEM_DEPTH-1 → 0.
- RD:
  - Drive bit k low if 0, release if 1.
  - On the 9th SCL rise, sample the controller's ACK.
    - ACK (SDA=0) → ptr+1 (wrap), load the next byte, continue RD.
    - NACK → IGNORE.
- IGNORE: lines released; exits only on START or STOP.
- Pointer persists across transactions, so a write-pointer transaction followed by a separate read transaction works.
- Simultaneous events:
  - START/STOP detection has priority over SCL-edge bit handling in the same cycle.
  - A write strobe and a read load never collide because the FSM is single-direction.

Optional Feature:
- Macro: I2C_RESP_STRETCH_EN.
- With the macro: after each ACK/NACK-bit SCL fall in WR_ACK, PTR_ACK and RD_ACK, scl_oe_o holds SCL low for STRETCH_CYCLES clk_i cycles, then releases. The bit FSM ignores SCL edges caused by its own stretch.
- Without the macro: no stretch logic; scl_oe_o tied 0.

Decomposition:
- Package i2c_resp_pkg:
  - state enum i2c_resp_state_t.
  - constant I2C_RW_READ=1'b1.
  - bit-counter width constant.
- Sub-module i2c_line_sync: synchronizers, scl_rise/scl_fall/start/stop pulses.

Test Plan:
- Write 0x22, ptr 0x03, data 0xA5, 0x5A, STOP → ACK on every byte; wr_strobe_o pulses with (3,A5) then (4,5A); busy_o falls after STOP.
- Write ptr 0x03, STOP; read 0x22, controller ACKs then NACKs → returns 0xA5, 0x5A; SDA released after NACK.
- Address 0x23 write → no ACK (SDA stays high on 9th clock); no strobe; memory unchanged.
- Write ptr 0x0F, data 0x11, 0x22, repeated START, read 1 byte → mem[15]=0x11, mem[0]=0x22 (wrap); read returns mem[1]=0x00.
- rst_i asserted mid-read while SDA is driven low → sda_oe_o=0 next cycle; memory reads back 0x00 afterwards.
- With I2C_RESP_STRETCH_EN, STRETCH_CYCLES=8: scl_oe_o high exactly 8 cycles after each ACK-bit SCL fall; data integrity unchanged.
